// File: rtl/pg_isolation_ctrl.sv
// Per-channel power-gating sequencer with output isolation.
// Each channel runs ON -> ISO -> OFF -> WAKE with programmable setup and wake delays.
module pg_isolation_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 32,
  parameter int ISO_SETUP  = 2,
  parameter int PWR_UP_CYC = 4,
  parameter int HOLD_MODE  = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       pgReq,
  input  logic [NUM_CH*WIDTH-1:0] dataIn,
  input  logic [NUM_CH*WIDTH-1:0] clampValue,
  output logic [NUM_CH*WIDTH-1:0] dataOut,
  output logic [NUM_CH-1:0]       sleepEn,
  output logic [NUM_CH-1:0]       clampEn,
  output logic [NUM_CH-1:0]       gated,
  output logic [NUM_CH-1:0]       busy,
  output logic                    allGated
);

  localparam int MAXD = (ISO_SETUP > PWR_UP_CYC) ? ISO_SETUP : PWR_UP_CYC;
  localparam int CW   = $clog2(MAXD + 1);

  localparam logic [1:0] ST_ON   = 2'd0;
  localparam logic [1:0] ST_ISO  = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;
  localparam logic [1:0] ST_WAKE = 2'd3;

  logic [NUM_CH-1:0] gated_nxt;
  logic              all_gated_q;
  logic              all_gated_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] din, cval;
    logic             clamp_q, clamp_d;
    logic             sleep_q, sleep_d;
    logic             gated_q, gated_d;
    logic             busy_q, busy_d;

    assign din  = dataIn[c*WIDTH +: WIDTH];
    assign cval = clampValue[c*WIDTH +: WIDTH];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        ST_ON: begin
          if (pgReq[c]) begin
            state_d = ST_ISO;
            cnt_d   = CW'(ISO_SETUP - 1);
          end
        end
        ST_ISO: begin
          if (!pgReq[c])           state_d = ST_ON;
          else if (cnt_q == '0)    state_d = ST_OFF;
          else                     cnt_d   = cnt_q - CW'(1);
        end
        ST_OFF: begin
          if (!pgReq[c]) begin
            state_d = ST_WAKE;
            cnt_d   = CW'(PWR_UP_CYC - 1);
          end
        end
        ST_WAKE: begin
          if (pgReq[c])            state_d = ST_OFF;
          else if (cnt_q == '0)    state_d = ST_ON;
          else                     cnt_d   = cnt_q - CW'(1);
        end
      endcase
      hold_d  = (state_q == ST_ON) ? din : hold_q;
      // outputs come from dedicated flops so they never glitch
      clamp_d = (state_d != ST_ON);
      sleep_d = (state_d == ST_OFF);
      gated_d = (state_d == ST_OFF);
      busy_d  = (state_d == ST_ISO) || (state_d == ST_WAKE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= ST_ON;
        cnt_q   <= '0;
        hold_q  <= '0;
        clamp_q <= 1'b0;
        sleep_q <= 1'b0;
        gated_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        hold_q  <= hold_d;
        clamp_q <= clamp_d;
        sleep_q <= sleep_d;
        gated_q <= gated_d;
        busy_q  <= busy_d;
      end
    end

    assign gated_nxt[c] = gated_d;
    assign clampEn[c]   = clamp_q;
    assign sleepEn[c]   = sleep_q;
    assign gated[c]     = gated_q;
    assign busy[c]      = busy_q;

    assign dataOut[c*WIDTH +: WIDTH] =
      clamp_q ? ((HOLD_MODE != 0) ? hold_q : cval) : din;
  end

  assign all_gated_d = &gated_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) all_gated_q <= 1'b0;
    else          all_gated_q <= all_gated_d;
  end

  assign allGated = all_gated_q;

endmodule

// File: tb/tb_pg_isolation_ctrl.sv
// Randomized scoreboard bench for pg_isolation_ctrl.
// Clamp-value and hold-mode instances run side by side against one model.
module tb_pg_isolation_ctrl;

  localparam int NC = 4;
  localparam int W  = 32;
  localparam int IS = 2;
  localparam int PU = 4;

  localparam int P_ON   = 0;
  localparam int P_ISO  = 1;
  localparam int P_OFF  = 2;
  localparam int P_WAKE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [NC-1:0] pg_req;
  logic [NC*W-1:0] din;
  logic [NC*W-1:0] cval;

  logic [NC*W-1:0] a_dout, b_dout;
  logic [NC-1:0] a_sl, a_cl, a_ga, a_bu;
  logic [NC-1:0] b_sl, b_cl, b_ga, b_bu;
  logic a_ag, b_ag;

  pg_isolation_ctrl #(
    .NUM_CH(NC), .WIDTH(W), .ISO_SETUP(IS),
    .PWR_UP_CYC(PU), .HOLD_MODE(0)
  ) u_clamp (
    .clk(clk), .reset_n(rst_n), .pgReq(pg_req),
    .dataIn(din), .clampValue(cval), .dataOut(a_dout),
    .sleepEn(a_sl), .clampEn(a_cl), .gated(a_ga),
    .busy(a_bu), .allGated(a_ag)
  );

  pg_isolation_ctrl #(
    .NUM_CH(NC), .WIDTH(W), .ISO_SETUP(IS),
    .PWR_UP_CYC(PU), .HOLD_MODE(1)
  ) u_hold (
    .clk(clk), .reset_n(rst_n), .pgReq(pg_req),
    .dataIn(din), .clampValue(cval), .dataOut(b_dout),
    .sleepEn(b_sl), .clampEn(b_cl), .gated(b_ga),
    .busy(b_bu), .allGated(b_ag)
  );

  typedef struct packed {
    logic [NC*W-1:0] d0;
    logic [NC*W-1:0] d1;
    logic [NC-1:0]   sl;
    logic [NC-1:0]   cl;
    logic [NC-1:0]   ga;
    logic [NC-1:0]   bu;
    logic            ag;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  bit done = 0;

  int ph[NC];
  int el[NC];
  logic [W-1:0] hold[NC];

  task automatic chk(input string nm, input logic [NC*W-1:0] act,
                     input logic [NC*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      ph[c] = P_ON;
      el[c] = 0;
      hold[c] = '0;
    end
  endtask

  // Phase + elapsed-cycles view of each channel
  task automatic model_edge();
    for (int c = 0; c < NC; c++) begin
      if (ph[c] == P_ON) hold[c] = din[c*W +: W];
      case (ph[c])
        P_ON: if (pg_req[c]) begin ph[c] = P_ISO; el[c] = 1; end
        P_ISO: begin
          if (!pg_req[c])      ph[c] = P_ON;
          else if (el[c] >= IS) ph[c] = P_OFF;
          else                 el[c]++;
        end
        P_OFF: if (!pg_req[c]) begin ph[c] = P_WAKE; el[c] = 1; end
        default: begin
          if (pg_req[c])        ph[c] = P_OFF;
          else if (el[c] >= PU) ph[c] = P_ON;
          else                  el[c]++;
        end
      endcase
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e = '0;
    e.ag = 1'b1;
    for (int c = 0; c < NC; c++) begin
      e.cl[c] = (ph[c] != P_ON);
      e.sl[c] = (ph[c] == P_OFF);
      e.ga[c] = (ph[c] == P_OFF);
      e.bu[c] = (ph[c] == P_ISO) || (ph[c] == P_WAKE);
      if (ph[c] != P_OFF) e.ag = 1'b0;
      e.d0[c*W +: W] = e.cl[c] ? cval[c*W +: W] : din[c*W +: W];
      e.d1[c*W +: W] = e.cl[c] ? hold[c] : din[c*W +: W];
    end
    q.push_back(e);
  endtask

  task automatic cycle(input logic [NC-1:0] pg, input logic rst);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    pg_req = pg;
    for (int c = 0; c < NC; c++) begin
      din[c*W +: W]  = $urandom;
      cval[c*W +: W] = $urandom;
    end
    rst_n = rst;
    if (!rst_n) model_reset();
    push_exp();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("dout_clamp", a_dout, e.d0);
        chk("dout_hold",  b_dout, e.d1);
        chk("sleep_a", {{(NC*W-NC){1'b0}}, a_sl}, {{(NC*W-NC){1'b0}}, e.sl});
        chk("clamp_a", {{(NC*W-NC){1'b0}}, a_cl}, {{(NC*W-NC){1'b0}}, e.cl});
        chk("gated_a", {{(NC*W-NC){1'b0}}, a_ga}, {{(NC*W-NC){1'b0}}, e.ga});
        chk("busy_a",  {{(NC*W-NC){1'b0}}, a_bu}, {{(NC*W-NC){1'b0}}, e.bu});
        chk("allg_a",  {{(NC*W-1){1'b0}}, a_ag}, {{(NC*W-1){1'b0}}, e.ag});
        chk("ctrl_b",  {{(NC*W-4*NC-1){1'b0}}, b_sl, b_cl, b_ga, b_bu, b_ag},
            {{(NC*W-4*NC-1){1'b0}}, e.sl, e.cl, e.ga, e.bu, e.ag});
      end
    end
  end

  initial begin : stim
    logic [NC-1:0] pg;
    rst_n = 1'b0;
    pg_req = '0;
    din = '0;
    cval = '0;
    model_reset();
    repeat (3) cycle('0, 1'b0);
    repeat (5) cycle('0, 1'b1);
    // ch0 gate then ungate
    repeat (12) cycle(4'b0001, 1'b1);
    repeat (8) cycle(4'b0000, 1'b1);
    // one-cycle pulse in ON
    cycle(4'b0001, 1'b1);
    repeat (3) cycle(4'b0000, 1'b1);
    // re-request two cycles into WAKE
    repeat (4) cycle(4'b0001, 1'b1);
    repeat (2) cycle(4'b0000, 1'b1);
    repeat (3) cycle(4'b0001, 1'b1);
    repeat (6) cycle(4'b0000, 1'b1);
    // all channels, reset during WAKE
    repeat (5) cycle(4'b1111, 1'b1);
    repeat (2) cycle(4'b0000, 1'b1);
    repeat (2) cycle(4'b0000, 1'b0);
    repeat (3) cycle(4'b0000, 1'b1);
    // fast toggling
    for (int i = 0; i < 10; i++) cycle((i % 2 == 0) ? 4'b1010 : 4'b0000, 1'b1);
    // slow random requests with occasional reset
    pg = '0;
    for (int i = 0; i < 500; i++) begin
      for (int c = 0; c < NC; c++)
        if ($urandom_range(4) == 0) pg[c] = ~pg[c];
      cycle(pg, ($urandom_range(149) != 0));
    end
    for (int i = 0; i < 100; i++) cycle(NC'($urandom), 1'b1);
    repeat (10) cycle('0, 1'b1);
    done = 1;
  end

  initial begin : ctrl
    for (int i = 0; i < 20000 && !done; i++) @(negedge clk);
    total++;
    if (!done) begin
      bad++;
      $display("FAIL timeout got=0 want=1");
    end
    repeat (2) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
